// File: rtl/inverse_result_collector.sv
// Buffers the inverter's row-major result stream and replays it
// to a consumer with row/col tags over a valid/ready handshake.
module inverse_result_collector #(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        order,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    input  logic              res_invertible,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic              busy,
    output logic              sing_err,
    output logic              ord_err,
    output logic              overrun
);

    localparam int DEPTH = MAX_N * MAX_N;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] MAX_ORD = 4'(MAX_N);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic              res_ready_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  last_idx;
    logic [3:0]        n_q;
    logic [3:0]        row;
    logic [3:0]        col;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             start;
    logic             ord_bad;
    logic             accept;
    logic             cap_we;
    logic             cap_done;
    logic             xfer;
    logic             col_wrap;
    logic [IDX_W-1:0] ord_i;
    logic [IDX_W-1:0] last_nx;
    logic [IDX_W-1:0] wr_addr;

    assign start    = res_ready & ~res_ready_q;
    assign ord_bad  = (order == 4'd0) || (order > MAX_ORD);
    assign accept   = (state == IDLE) && start
                      && !ord_bad && res_invertible;
    // N*N-1 fits in IDX_W bits, so modular math is exact here
    assign ord_i    = IDX_W'(order);
    assign last_nx  = ord_i * ord_i - IDX_W'(1);
    assign cap_done = (state == CAPTURE) && (idx == last_idx);
    assign xfer     = out_valid & out_ready;
    assign col_wrap = (col == n_q - 4'd1);

    assign cap_we   = accept || (state == CAPTURE);
    assign wr_addr  = (state == CAPTURE) ? idx : '0;

    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (rd_idx == last_idx);
    assign out_data  = out_valid ? mem[rd_idx] : '0;
    assign out_row   = row;
    assign out_col   = col;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (order == 4'd1) ? DRAIN : CAPTURE;
                end
            end
            CAPTURE: begin
                if (cap_done) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && out_last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_ready_q <= 1'b0;
            sing_err    <= 1'b0;
            ord_err     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            res_ready_q <= res_ready;
            sing_err    <= 1'b0;
            ord_err     <= 1'b0;
            if (start && state == IDLE) begin
                unique case (1'b1)
                    ord_bad:
                        ord_err <= 1'b1;
                    !ord_bad && !res_invertible:
                        sing_err <= 1'b1;
                    default: ;
                endcase
            end
            // a new result cannot be accepted mid-transfer
            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            last_idx <= '0;
            n_q      <= 4'd0;
        end else if (accept) begin
            idx      <= IDX_W'(1);
            last_idx <= last_nx;
            n_q      <= order;
        end else if (state == CAPTURE) begin
            idx <= idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx <= '0;
            row    <= 4'd0;
            col    <= 4'd0;
        end else if (accept) begin
            rd_idx <= '0;
            row    <= 4'd0;
            col    <= 4'd0;
        end else if (xfer) begin
            if (out_last) begin
                rd_idx <= '0;
                row    <= 4'd0;
                col    <= 4'd0;
            end else begin
                rd_idx <= rd_idx + IDX_W'(1);
                if (col_wrap) begin
                    col <= 4'd0;
                    row <= row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && cap_we) begin
            mem[wr_addr] <= res_data;
        end
    end

endmodule
